// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by the digit separator.
// A byte is accepted in IDLE when tx_start is high; tx_done is a level that
// reads 1 while the transmitter is idle and ready for the next byte.
// Optional feature: define PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit (8E1 framing).
module uart_tx #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DBIT         = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DBIT - 1);

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [DBIT-1:0]  shreg;
    logic [DBIT-1:0]  shreg_nxt;
    logic             baud_end;
`ifdef PARITY_EN
    logic             par_bit;
`endif

    // Terminal count of the current bit period and the next shifted byte
    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign shreg_nxt = shreg >> 1;

    // Frame sequencer: every output is registered so tx never glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_done  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    tx_done <= 1'b1;
                    if (tx_start) begin
                        // Byte is captured here; later din changes are ignored
                        shreg    <= din;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        tx_done  <= 1'b0;
                        state    <= START;
`ifdef PARITY_EN
                        par_bit  <= ^din;
`endif
                    end
                end

                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shreg    <= shreg_nxt;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef PARITY_EN
                            tx      <= par_bit;
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg_nxt[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (baud_end) begin
                        // Ready flag rises on the same edge the stop bit ends
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        tx_done  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_done <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with a line-level receiver model.
// Honours PARITY_EN the same way the design does.
module tb_uart_tx;

    localparam int CPB  = 4;
    localparam int DBIT = 8;
`ifdef PARITY_EN
    localparam int NBITS = DBIT + 3;
`else
    localparam int NBITS = DBIT + 2;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx;
    logic       tx_done;

    typedef struct {
        logic [7:0] data;
        bit         abort;
        bit         gap_chk;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rx_q[$];
    bit         samp[$];
    int         vectors = 0;
    int         miscompares = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .DBIT(DBIT)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .din      (din),
        .tx       (tx),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line levels of one frame, slot 0 first: start, data LSB first, [parity], stop
    function automatic logic [15:0] frame_bits(input logic [7:0] d);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int k = 0; k < DBIT; k++) f[k+1] = d[k];
`ifdef PARITY_EN
        f[DBIT+1] = ^d;
`endif
        return f;
    endfunction

    // Monitor: captures each tx_done-low window and checks it against the scoreboard
    initial begin : monitor
        bit         prev_done;
        int         idle_run;
        bit         aborted;
        bit         rst_pend;
        bit         timed_out;
        exp_t       e;
        logic [15:0] fb;
        logic [7:0] rxb;
        int         bad;
        prev_done = 1'b1;
        idle_run  = 0;
        forever begin
            @(negedge clk);
            if (!(prev_done && tx_done === 1'b0)) begin
                if (tx_done === 1'b1) idle_run++;
                else idle_run = 0;
                prev_done = (tx_done === 1'b1);
                continue;
            end
            samp.delete();
            samp.push_back(tx);
            aborted   = 1'b0;
            timed_out = 1'b0;
            rst_pend  = reset;
            forever begin
                @(negedge clk);
                if (rst_pend) begin
                    aborted = 1'b1;
                    check("rst_abort_idle", {30'd0, tx, tx_done}, 32'd3);
                    break;
                end
                if (tx_done === 1'b1) break;
                samp.push_back(tx);
                rst_pend = reset;
                if (samp.size() > FRAME_CYC + 8) begin
                    timed_out = 1'b1;
                    check("frame_timeout", samp.size(), FRAME_CYC);
                    break;
                end
            end
            if (sb.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                if (e.gap_chk) check("b2b_gap", idle_run, 1);
                check("abort_match", {31'd0, aborted}, {31'd0, e.abort});
                if (!aborted && !e.abort && !timed_out) begin
                    check("busy_len", samp.size(), FRAME_CYC);
                    fb  = frame_bits(e.data);
                    bad = 0;
                    for (int i = 0; i < samp.size(); i++)
                        if (i >= FRAME_CYC || samp[i] !== fb[i / CPB]) bad++;
                    check("frame_wave", bad, 0);
                    if (samp.size() == FRAME_CYC) begin
                        for (int k = 0; k < DBIT; k++) rxb[k] = samp[(k + 1) * CPB + CPB / 2];
                        rx_q.push_back(rxb);
                        check("rx_byte", {24'd0, rxb}, {24'd0, e.data});
`ifdef PARITY_EN
                        check("rx_parity", {31'd0, samp[(DBIT + 1) * CPB + CPB / 2]}, {31'd0, ^e.data});
`endif
                    end
                end
            end
            prev_done = 1'b1;
            idle_run  = 1;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_done !== 1'b1 && n < 3 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        if (tx_done !== 1'b1) check("idle_timeout", {31'd0, tx_done}, 32'd1);
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (tx_done !== 1'b0 && n < 3 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        if (tx_done !== 1'b0) check("busy_timeout", {31'd0, tx_done}, 32'd0);
    endtask

    // One-cycle tx_start pulse; tx and tx_done must both drop one cycle later
    task automatic send_byte(input logic [7:0] b, input bit ab);
        wait_idle();
        @(negedge clk);
        din      = b;
        tx_start = 1'b1;
        sb.push_back('{data: b, abort: ab, gap_chk: 1'b0});
        @(negedge clk);
        tx_start = 1'b0;
        check("accept_latency", {30'd0, tx, tx_done}, 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [7:0] digits [3];
        int n;
        digits[0] = 8'h31;
        digits[1] = 8'h32;
        digits[2] = 8'h33;

        // Reset held with a pending request: line stays idle
        reset    = 1'b1;
        tx_start = 1'b1;
        din      = 8'hFF;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_state", {30'd0, tx, tx_done}, 32'd3);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        tx_start = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tx_done !== 1'b1 || tx !== 1'b1) n++;
        end
        check("no_frame_after_reset", n, 0);

        // Single byte 0x31
        send_byte(8'h31, 1'b0);
        wait_idle();

        // Busy rejection: request mid-frame must neither corrupt nor queue
        send_byte(8'h31, 1'b0);
        repeat (10) @(negedge clk);
        din      = 8'hAA;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle();
        repeat (FRAME_CYC / 2) @(negedge clk);
        check("no_requeue", {31'd0, tx_done}, 32'd1);

        // Back-to-back digits with tx_start held high
        repeat (2) @(negedge clk);
        rx_q.delete();
        din      = digits[0];
        sb.push_back('{data: digits[0], abort: 1'b0, gap_chk: 1'b0});
        tx_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_busy();
            if (i < 2) begin
                din = digits[i+1];
                sb.push_back('{data: digits[i+1], abort: 1'b0, gap_chk: 1'b1});
                wait_idle();
            end
        end
        tx_start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("rx_count", rx_q.size(), 3);
        if (rx_q.size() == 3)
            check("rx_string_123", {8'd0, rx_q[0], rx_q[1], rx_q[2]}, 32'h00313233);

        // Reset during data bit 3, then a clean frame
        send_byte(8'h5A, 1'b1);
        repeat (4 * CPB + 1) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h34, 1'b0);
        wait_idle();

        // Random bytes with din churn and stray requests while busy
        for (int f = 0; f < 10; f++) begin
            send_byte(8'($urandom_range(0, 255)), 1'b0);
            n = 0;
            while (tx_done !== 1'b1 && n < 3 * FRAME_CYC) begin
                @(negedge clk);
                n++;
                din      = 8'($urandom_range(0, 255));
                tx_start = ($urandom_range(0, 15) == 0) && (tx_done === 1'b0);
            end
            tx_start = 1'b0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        wait_idle();
        repeat (FRAME_CYC / 2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
